// File: rtl/pla_6i_1_preimage.sv
// Preimage enumerator for a 6-input, 1-output truth table: on request, scans
// x = 0..63 in order and streams every x with f(x) == target over a valid/ready port.
module pla_6i_1_preimage #(
  parameter logic [63:0] TRUTH_TABLE = 64'h50D9_D5EB_5327_57FA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_x,
  output logic       done,
  output logic [6:0] match_count,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid & ready are both
  // high; once out_valid is raised, out_valid/out_x hold until that transfer.
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic        target_q, target_d;
  logic [5:0]  idx_q, idx_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [5:0]  out_x_q, out_x_d;
  logic        done_q, done_d;
  logic [6:0]  match_count_q, match_count_d;

  logic        advance;
  logic        match;

  // The output register can take a new beat when empty or being drained now.
  assign advance = ~out_valid_q | out_ready;
  assign match   = (TRUTH_TABLE[idx_q] == target_q);

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_x_d       = out_x_q;
    done_d        = 1'b0;
    match_count_d = match_count_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          idx_d    = 6'd0;
          cnt_d    = 7'd0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          if (match) begin
            out_x_d     = idx_q;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 7'd1;
          end
          if (idx_q == 6'd63) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      DRAIN: begin
        if (advance) begin
          state_d       = DONE;
          done_d        = 1'b1;
          match_count_d = cnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      target_q      <= 1'b0;
      idx_q         <= 6'd0;
      cnt_q         <= 7'd0;
      out_valid_q   <= 1'b0;
      out_x_q       <= 6'd0;
      done_q        <= 1'b0;
      match_count_q <= 7'd0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_x_q       <= out_x_d;
      done_q        <= done_d;
      match_count_q <= match_count_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_x       = out_x_q;
  assign done        = done_q;
  assign match_count = match_count_q;
  assign dbg_state   = state_q;

endmodule
